seq_scan_ctrl: RTL
==================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter W, default 8: input word width in bits, W >= 4.
REQ-002 Parameter KEEP_HIST, default 0: 1 carries detector state across words; 0 resets detector to S0 on each word accept.
REQ-003 Parameter TOT_W, default 16: width of running total counter.
REQ-004 Local constant CNT_W = clog2(W+1): per-word count width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream word available.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 in_data  input  W  word to scan, serialized MSB first.
REQ-010 clear_hist  input  1  synchronous detector-state clear, honoured only in IDLE.
REQ-011 out_valid  output  1  per-word result available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_count  output  CNT_W  number of "1001" matches completed within the word.
REQ-014 total_count  output  TOT_W  running match total since reset, saturating.

Function
REQ-015 Controller FSM SHALL have states IDLE, SHIFT, REPORT.
REQ-016 in_ready SHALL equal (state == IDLE), decoded from state only.
REQ-017 IDLE: on in_valid && in_ready, SHALL load in_data into the shift register, set bit index to W-1, clear out_count, enter SHIFT; if KEEP_HIST=0, detector SHALL be forced to S0 on the same edge.
REQ-018 SHIFT: SHALL present exactly one bit per cycle, MSB first, for W cycles, then enter REPORT.
REQ-019 Detector SHALL be the overlapping Mealy "1001" machine: S0 -1-> S1, S0 -0-> S0; S1 -0-> S2, S1 -1-> S1; S2 -0-> S3, S2 -1-> S1; S3 -1-> S1 (match), S3 -0-> S0.
REQ-020 Match SHALL be combinational (state S3 && bit == 1) and SHALL increment out_count and total_count on the same edge the bit is consumed.
REQ-021 total_count SHALL saturate at all-ones and never wrap.
REQ-022 REPORT: out_valid SHALL be 1; out_count SHALL stay stable until out_valid && out_ready, then the FSM SHALL enter IDLE and drop out_valid.
REQ-023 Latency: word accepted at edge N yields out_valid high from edge N+W+1; minimum word-to-word spacing W+2 cycles.
REQ-024 in_valid in SHIFT or REPORT SHALL be ignored (no accept, no data capture).
REQ-025 clear_hist in IDLE SHALL force detector to S0; if coincident with accept, clear takes effect and the new word scans from S0; in SHIFT/REPORT clear_hist SHALL be ignored.
REQ-026 Detector state SHALL not advance outside SHIFT.

Reset
REQ-027 On rst low, asynchronously: state IDLE, detector S0, out_valid 0, out_count 0, total_count 0, shift register 0, bit index 0.
REQ-028 Reset mid-SHIFT or mid-REPORT SHALL abandon the word with no result emitted; in_ready SHALL read 1 during and after reset.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (IDLE/SHIFT/REPORT), detector state encoding (S0..S3, 2 bits) and the clog2 helper.
REQ-030 Detector SHALL be a sub-module seq_det_core (inputs clk, rst, en, clr, bit; outputs match, state), instantiated once.

Verification
REQ-031 KEEP_HIST=0, word 0x99 -> out_count 2 at cycle N+9, total_count 2.
REQ-032 KEEP_HIST=1, word 0x04 then 0x80 -> counts 0 then 1; same stimulus with KEEP_HIST=0 -> 0 then 0.
REQ-033 Word 0x49, out_ready held 0 for 5 cycles -> out_valid and out_count=2 stable, in_ready 0, pulsed in_valid with 0xFF not captured.
REQ-034 rst asserted 3 cycles into SHIFT of 0x49 -> out_valid 0, out_count 0, total_count 0, in_ready 1; next word 0x92 -> out_count 2.
REQ-035 TOT_W=2, words 0x49, 0x49 -> total_count 2 then 3 (saturated, not 0).
REQ-036 KEEP_HIST=1, word 0x04, clear_hist pulsed in IDLE, then 0x80 -> count 0.

Source files
------------

// File: rtl/seq_scan_ctrl_pkg.sv
// Shared encodings and helpers for the "1001" sequence scan controller.
package seq_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_det.sv
// Overlapping Mealy detector for the serial pattern "1001"; advances only when en is high.
module seq_det_core
  import seq_scan_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       data_bit,
  output logic       match,
  output det_state_t state
);

  det_state_t state_next;

  always_comb begin
    state_next = S0;
    case (state)
      S0: state_next = data_bit ? S1 : S0;
      S1: state_next = data_bit ? S1 : S2;
      S2: state_next = data_bit ? S1 : S3;
      S3: state_next = data_bit ? S1 : S0;
      default: state_next = S0;
    endcase
  end

  assign match = en && (state == S3) && data_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
    end else if (clr) begin
      state <= S0;
    end else if (en) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-serial "1001" scanner: accepts a word, shifts it MSB first through the
// detector, then holds the per-word match count until downstream takes it.
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int W         = 8,
  parameter int KEEP_HIST = 0,
  parameter int TOT_W     = 16,
  localparam int CNT_W    = clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             clear_hist,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [TOT_W-1:0] total_count
);

  localparam int IDX_W = clog2(W);

  ctrl_state_t      state_reg;
  logic [W-1:0]     shift_reg;
  logic [IDX_W-1:0] idx_reg;

  logic       accept;
  logic       det_en;
  logic       det_clr;
  logic       det_match;
  logic       hit;
  det_state_t det_state;

  assign in_ready = (state_reg == IDLE);
  assign accept   = in_valid && in_ready;
  assign det_en   = (state_reg == SHIFT);
  // Without history, every accepted word restarts the detector from S0.
  assign det_clr  = (state_reg == IDLE) && (clear_hist || (accept && (KEEP_HIST == 0)));
  assign hit      = det_match && (det_state == S3);

  seq_det_core u_det (
    .clk      (clk),
    .rst      (rst),
    .en       (det_en),
    .clr      (det_clr),
    .data_bit (shift_reg[W-1]),
    .match    (det_match),
    .state    (det_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      idx_reg     <= '0;
      out_valid   <= 1'b0;
      out_count   <= '0;
      total_count <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_reg <= in_data;
            idx_reg   <= IDX_W'(W - 1);
            out_count <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[W-2:0], 1'b0};
          if (hit) begin
            out_count <= out_count + CNT_W'(1);
            if (total_count != {TOT_W{1'b1}}) begin
              total_count <= total_count + TOT_W'(1);
            end
          end
          if (idx_reg == '0) begin
            state_reg <= REPORT;
            out_valid <= 1'b1;
          end else begin
            idx_reg <= idx_reg - IDX_W'(1);
          end
        end
        REPORT: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
